// File: rtl/cpu_datapath_if.sv
// Control-word / status bundle between the CPU controller and cpu_datapath.
//   master : controller side, drives the strobes and operands, reads C and the flags
//   slave  : datapath side
// Signals: write, writenum, readnum, vsel, loada, loadb, asel, bsel, shift, ALUop,
//          loadc, loads, sximm8, sximm5, mdata, PC  (controller -> datapath)
//          datapath_out, Z_out, N_out, V_out        (datapath -> controller)
interface cpu_datapath_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned IDX_W    = 3
);
  logic                write;
  logic [IDX_W-1:0]    writenum;
  logic [IDX_W-1:0]    readnum;
  logic [1:0]          vsel;
  logic                loada;
  logic                loadb;
  logic                asel;
  logic                bsel;
  logic [1:0]          shift;
  logic [1:0]          ALUop;
  logic                loadc;
  logic                loads;
  logic [WIDTH-1:0]    sximm8;
  logic [WIDTH-1:0]    sximm5;
  logic [WIDTH-1:0]    mdata;
  logic [PC_WIDTH-1:0] PC;
  logic [WIDTH-1:0]    datapath_out;
  logic                Z_out;
  logic                N_out;
  logic                V_out;

  modport master (
    output write, writenum, readnum, vsel, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, sximm8, sximm5, mdata, PC,
    input  datapath_out, Z_out, N_out, V_out
  );

  modport slave (
    input  write, writenum, readnum, vsel, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, sximm8, sximm5, mdata, PC,
    output datapath_out, Z_out, N_out, V_out
  );
endinterface

// File: rtl/cpu_datapath.sv
// Execution datapath: 8x16 register file, operand registers A/B, B-side shifter,
// ALU, result register C and the Z/N/V status flags.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, overrides every load and write
//   dp    : cpu_datapath_if.slave control word in, datapath_out/Z_out/N_out/V_out out
// Build option:
//   REGFILE_FORWARD_EN : a write to the register being read is bypassed onto the
//                        read data in the same cycle; otherwise the old value is read.
module cpu_datapath #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned PC_WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  cpu_datapath_if.slave dp
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             z_q, z_d, n_q, n_d, v_q, v_d;
  logic [WIDTH-1:0] data_in, read_data, b_sh, ain, bin, alu_res;
  logic             alu_v;

  // Writeback source select
  always_comb begin
    data_in = c_q;
    case (dp.vsel)
      2'b00:   data_in = c_q;
      2'b01:   data_in = WIDTH'(dp.PC);
      2'b10:   data_in = dp.sximm8;
      default: data_in = dp.mdata;
    endcase
  end

  // Combinational register read, optionally bypassing a same-index write
  always_comb begin
    read_data = rf_q[dp.readnum];
`ifdef REGFILE_FORWARD_EN
    if (dp.write && (dp.writenum == dp.readnum)) read_data = data_in;
`endif
  end

  // Shifter on B
  always_comb begin
    b_sh = b_q;
    case (dp.shift)
      2'b00:   b_sh = b_q;
      2'b01:   b_sh = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[WIDTH-1:1]};
      default: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
    endcase
  end

  assign ain = dp.asel ? '0 : a_q;
  assign bin = dp.bsel ? dp.sximm5 : b_sh;

  // ALU; overflow judged from operand and result sign bits
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (dp.ALUop)
      2'b00: begin
        alu_res = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b01: begin
        alu_res = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  // Next-state for the operand, result and status registers
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    z_d = z_q;
    n_d = n_q;
    v_d = v_q;
    if (dp.loada) a_d = read_data;
    if (dp.loadb) b_d = read_data;
    if (dp.loadc) c_d = alu_res;
    if (dp.loads) begin
      z_d = (alu_res == '0);
      n_d = alu_res[WIDTH-1];
      v_d = alu_v;
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[IDX_W'(i)] <= '0;
    end else if (dp.write) begin
      rf_q[dp.writenum] <= data_in;
    end
  end

  // Operand / result / status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign dp.datapath_out = c_q;
  assign dp.Z_out        = z_q;
  assign dp.N_out        = n_q;
  assign dp.V_out        = v_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus a randomized
// control-word stream checked against an arithmetic reference model.
module tb_cpu_datapath;
  typedef struct packed {
    logic        reset;
    logic        write;
    logic [2:0]  wn;
    logic [2:0]  rn;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [15:0] mdata;
    logic [7:0]  pc;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_datapath_if #(.WIDTH(16), .PC_WIDTH(8), .IDX_W(3)) dp_if ();

  cpu_datapath #(.WIDTH(16), .NREGS(8), .PC_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if)
  );

  // Reference model state
  logic [15:0] m_rf [8];
  logic [15:0] m_a, m_b, m_c;
  logic        m_z, m_n, m_v;

  // Apply one control word for one clock and advance the model alongside
  task automatic step(input ctl_t c);
    logic [15:0] din, rd, bs, ai, bi, res;
    int          sa, sb, full;
    logic        ov;
    reset           = c.reset;
    dp_if.write     = c.write;
    dp_if.writenum  = c.wn;
    dp_if.readnum   = c.rn;
    dp_if.vsel      = c.vsel;
    dp_if.loada     = c.loada;
    dp_if.loadb     = c.loadb;
    dp_if.asel      = c.asel;
    dp_if.bsel      = c.bsel;
    dp_if.shift     = c.shift;
    dp_if.ALUop     = c.aluop;
    dp_if.loadc     = c.loadc;
    dp_if.loads     = c.loads;
    dp_if.sximm8    = c.sximm8;
    dp_if.sximm5    = c.sximm5;
    dp_if.mdata     = c.mdata;
    dp_if.PC        = c.pc;

    case (c.vsel)
      2'd0:    din = m_c;
      2'd1:    din = {8'h00, c.pc};
      2'd2:    din = c.sximm8;
      default: din = c.mdata;
    endcase
    rd = m_rf[c.rn];
`ifdef REGFILE_FORWARD_EN
    if (c.write && c.wn == c.rn) rd = din;
`endif
    case (c.shift)
      2'd0:    bs = m_b;
      2'd1:    bs = 16'((int'(m_b) * 2) % 65536);
      2'd2:    bs = 16'(int'(m_b) / 2);
      default: bs = 16'(($signed(m_b) < 0) ? (int'(m_b) / 2 + 32768) : (int'(m_b) / 2));
    endcase
    ai = c.asel ? 16'h0 : m_a;
    bi = c.bsel ? c.sximm5 : bs;
    sa = int'($signed(ai));
    sb = int'($signed(bi));
    ov = 1'b0;
    case (c.aluop)
      2'd0: begin full = sa + sb; res = 16'(full); ov = (full > 32767) || (full < -32768); end
      2'd1: begin full = sa - sb; res = 16'(full); ov = (full > 32767) || (full < -32768); end
      2'd2:    res = ai & bi;
      default: res = 16'(65535 - int'(bi));
    endcase

    @(posedge clk);
    #1;
    if (c.reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
      m_z = 1'b0;  m_n = 1'b0;  m_v = 1'b0;
    end else begin
      if (c.write) m_rf[c.wn] = din;
      if (c.loada) m_a = rd;
      if (c.loadb) m_b = rd;
      if (c.loadc) m_c = res;
      if (c.loads) begin
        m_z = (res == 16'h0);
        m_n = ($signed(res) < 0);
        m_v = ov;
      end
    end
  endtask

  task automatic write_reg(input logic [2:0] r, input logic [15:0] val);
    ctl_t c = '0;
    c.write = 1'b1; c.wn = r; c.vsel = 2'd3; c.mdata = val;
    step(c);
  endtask

  // Observe a register through B -> (0 + B) -> C
  task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
    ctl_t c = '0;
    c.rn = r; c.loadb = 1'b1;
    step(c);
    c = '0;
    c.asel = 1'b1; c.loadc = 1'b1;
    step(c);
    val = dp_if.datapath_out;
  endtask

  task automatic test_reset();
    ctl_t c = '0;
    c.reset = 1'b1; c.loadc = 1'b1; c.loads = 1'b1; c.asel = 1'b1; c.bsel = 1'b1;
    c.sximm5 = 16'hFFFF;
    step(c);
    total++; if (dp_if.datapath_out !== 16'h0) begin bad++; $display("FAIL reset_c: got %h want 0000", dp_if.datapath_out); end
    total++; if (dp_if.Z_out !== 1'b0) begin bad++; $display("FAIL reset_z: got %b want 0", dp_if.Z_out); end
    total++; if (dp_if.N_out !== 1'b0) begin bad++; $display("FAIL reset_n: got %b want 0", dp_if.N_out); end
    total++; if (dp_if.V_out !== 1'b0) begin bad++; $display("FAIL reset_v: got %b want 0", dp_if.V_out); end
  endtask

  task automatic test_regfile();
    ctl_t        c = '0;
    logic [15:0] v;
    c.write = 1'b1; c.wn = 3'd0; c.vsel = 2'd2; c.sximm8 = 16'h0007;
    step(c);
    read_reg(3'd0, v);
    total++; if (v !== 16'h0007) begin bad++; $display("FAIL regfile_r0: got %h want 0007", v); end
    c = '0; c.write = 1'b1; c.wn = 3'd7; c.vsel = 2'd1; c.pc = 8'hA5;
    step(c);
    read_reg(3'd7, v);
    total++; if (v !== 16'h00A5) begin bad++; $display("FAIL regfile_pc: got %h want 00a5", v); end
  endtask

  task automatic test_add();
    ctl_t        c = '0;
    logic [15:0] v;
    c.write = 1'b1; c.wn = 3'd1; c.vsel = 2'd2; c.sximm8 = 16'h0002;
    step(c);
    c = '0; c.rn = 3'd1; c.loada = 1'b1; step(c);
    c = '0; c.rn = 3'd0; c.loadb = 1'b1; step(c);
    c = '0; c.shift = 2'd1; c.loadc = 1'b1; c.loads = 1'b1; step(c);
    total++; if (dp_if.datapath_out !== 16'h0010) begin bad++; $display("FAIL add_c: got %h want 0010", dp_if.datapath_out); end
    total++; if ({dp_if.Z_out, dp_if.N_out, dp_if.V_out} !== 3'b000) begin
      bad++; $display("FAIL add_flags: got ZNV=%b want 000", {dp_if.Z_out, dp_if.N_out, dp_if.V_out}); end
    c = '0; c.write = 1'b1; c.wn = 3'd2; c.vsel = 2'd0; step(c);
    read_reg(3'd2, v);
    total++; if (v !== 16'h0010) begin bad++; $display("FAIL add_wb_r2: got %h want 0010", v); end
  endtask

  task automatic test_overflow();
    ctl_t c = '0;
    write_reg(3'd4, 16'h8000);
    write_reg(3'd5, 16'h0001);
    c.rn = 3'd4; c.loada = 1'b1; step(c);
    c = '0; c.rn = 3'd5; c.loadb = 1'b1; step(c);
    c = '0; c.aluop = 2'd1; c.loadc = 1'b1; c.loads = 1'b1; step(c);
    total++; if (dp_if.datapath_out !== 16'h7FFF) begin bad++; $display("FAIL ovf_c: got %h want 7fff", dp_if.datapath_out); end
    total++; if (dp_if.V_out !== 1'b1) begin bad++; $display("FAIL ovf_v: got %b want 1", dp_if.V_out); end
    total++; if (dp_if.N_out !== 1'b0) begin bad++; $display("FAIL ovf_n: got %b want 0", dp_if.N_out); end
    total++; if (dp_if.Z_out !== 1'b0) begin bad++; $display("FAIL ovf_z: got %b want 0", dp_if.Z_out); end
  endtask

  task automatic test_compare();
    ctl_t c = '0;
    write_reg(3'd6, 16'h0005);
    c.rn = 3'd6; c.loada = 1'b1; c.loadb = 1'b1; step(c);
    c = '0; c.aluop = 2'd1; c.loads = 1'b1; step(c);
    total++; if (dp_if.Z_out !== 1'b1) begin bad++; $display("FAIL cmp_z: got %b want 1", dp_if.Z_out); end
    total++; if (dp_if.N_out !== 1'b0) begin bad++; $display("FAIL cmp_n: got %b want 0", dp_if.N_out); end
    total++; if (dp_if.V_out !== 1'b0) begin bad++; $display("FAIL cmp_v: got %b want 0", dp_if.V_out); end
    total++; if (dp_if.datapath_out !== 16'h7FFF) begin bad++; $display("FAIL cmp_c_hold: got %h want 7fff", dp_if.datapath_out); end
  endtask

  task automatic test_reset_priority();
    ctl_t        c = '0;
    logic [15:0] v;
    c.reset = 1'b1; c.loada = 1'b1; c.rn = 3'd6; c.write = 1'b1; c.wn = 3'd0;
    c.vsel = 2'd2; c.sximm8 = 16'h0055; c.loads = 1'b1; c.aluop = 2'd3;
    step(c);
    total++; if (dp_if.datapath_out !== 16'h0) begin bad++; $display("FAIL rstp_c: got %h want 0000", dp_if.datapath_out); end
    total++; if ({dp_if.Z_out, dp_if.N_out, dp_if.V_out} !== 3'b000) begin
      bad++; $display("FAIL rstp_flags: got ZNV=%b want 000", {dp_if.Z_out, dp_if.N_out, dp_if.V_out}); end
    c = '0; c.bsel = 1'b1; c.loadc = 1'b1; step(c);   // C = A + 0
    total++; if (dp_if.datapath_out !== 16'h0) begin bad++; $display("FAIL rstp_a: got %h want 0000", dp_if.datapath_out); end
    read_reg(3'd0, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL rstp_r0: got %h want 0000", v); end
    read_reg(3'd6, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL rstp_r6: got %h want 0000", v); end
  endtask

  task automatic test_same_index();
    ctl_t        c = '0;
    logic [15:0] v, exp_a;
`ifdef REGFILE_FORWARD_EN
    exp_a = 16'h1234;
`else
    exp_a = 16'h0000;
`endif
    c.write = 1'b1; c.wn = 3'd3; c.rn = 3'd3; c.loada = 1'b1; c.vsel = 2'd3; c.mdata = 16'h1234;
    step(c);
    c = '0; c.bsel = 1'b1; c.loadc = 1'b1; step(c);
    total++; if (dp_if.datapath_out !== exp_a) begin bad++; $display("FAIL same_idx_a: got %h want %h", dp_if.datapath_out, exp_a); end
    read_reg(3'd3, v);
    total++; if (v !== 16'h1234) begin bad++; $display("FAIL same_idx_r3: got %h want 1234", v); end
  endtask

  task automatic test_random();
    ctl_t        c;
    logic [4:0]  i5;
    logic [7:0]  i8;
    for (int n = 0; n < 400; n++) begin
      c        = ctl_t'({$urandom, $urandom, $urandom, $urandom});
      c.reset  = ($urandom_range(0, 31) == 0);
      i5       = 5'($urandom);
      i8       = 8'($urandom);
      c.sximm5 = {{11{i5[4]}}, i5};
      c.sximm8 = {{8{i8[7]}}, i8};
      step(c);
      total++; if (dp_if.datapath_out !== m_c) begin bad++; $display("FAIL rand_c[%0d]: got %h want %h", n, dp_if.datapath_out, m_c); end
      total++; if (dp_if.Z_out !== m_z) begin bad++; $display("FAIL rand_z[%0d]: got %b want %b", n, dp_if.Z_out, m_z); end
      total++; if (dp_if.N_out !== m_n) begin bad++; $display("FAIL rand_n[%0d]: got %b want %b", n, dp_if.N_out, m_n); end
      total++; if (dp_if.V_out !== m_v) begin bad++; $display("FAIL rand_v[%0d]: got %b want %b", n, dp_if.V_out, m_v); end
    end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_add();
    test_overflow();
    test_compare();
    test_reset_priority();
    test_same_index();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
